fifo_banco_dispositivos: RTL and testbench

Parametrised bank of independent per-device FIFOs. It replaces the single-channel fifo as the buffering stage between each bus device and the shared bus. Each channel has its own push/pop handshake and occupancy count. Each channel also has a programmable almost-full threshold, sticky overflow/underflow flags, and a selectable output mode: registered read or first-word-fall-through (FWFT).

---
 rtl/fifo_banco_dispositivos_pkg.sv | 13 +
 rtl/fifo_banco_dispositivos_canal.sv | 128 ++++++++++++
 rtl/fifo_banco_dispositivos.sv | 51 +++++
 tb/tb_fifo_banco_dispositivos.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_banco_dispositivos_pkg.sv
// Shared definitions for the per-device FIFO bank.
// Holds the read-mode encoding and the occupancy-width helper.
package fifo_pkg;

    localparam int MODO_REG  = 0;
    localparam int MODO_FWFT = 1;

    // Occupancy must represent 0..depth inclusive.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_banco_dispositivos_canal.sv
// Single FIFO channel with explicit occupancy counter,
// sticky error flags and registered or fall-through read data.
module fifo_canal
    import fifo_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 8,
    parameter int fwft  = MODO_REG,
    localparam int cnt_w = calc_cnt_w(depth),
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] dato_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [cnt_w-1:0] umbral_i,
    input  logic             clr_flags_i,
    output logic [width-1:0] dato_o,
    output logic             pndng_o,
    output logic             full_o,
    output logic             almost_full_o,
    output logic [cnt_w-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic [width-1:0] dato_q, dato_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [width-1:0] mem_q [depth];

    logic vacio;
    logic lleno;
    logic do_push;
    logic do_pop;

    // Pointers wrap at depth-1 so any depth works, not only powers of two.
    function automatic logic [ptr_w-1:0] sig_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign vacio   = (count_q == '0);
    assign lleno   = (count_q == cnt_w'(depth));
    assign do_pop  = pop_i && !vacio;
    // A full FIFO still accepts a word when a pop frees a slot that cycle.
    assign do_push = push_i && (!lleno || pop_i);

    // Next-state for pointers, occupancy, read data and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dato_d   = dato_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (do_push) begin
            wr_ptr_d = sig_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = sig_ptr(rd_ptr_q);
            dato_d   = mem_q[rd_ptr_q];
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase

        if (clr_flags_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (push_i && lleno && !pop_i) begin
                ovf_d = 1'b1;
            end
            if (pop_i && vacio) begin
                unf_d = 1'b1;
            end
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dato_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dato_q   <= dato_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents survive reset but become unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= dato_i;
        end
    end

    // Fall-through shows the head word, else the last popped word.
    if (fwft == MODO_FWFT) begin : g_fwft
        assign dato_o = vacio ? dato_q : mem_q[rd_ptr_q];
    end else begin : g_reg
        assign dato_o = dato_q;
    end

    assign pndng_o       = !vacio;
    assign full_o        = lleno;
    assign almost_full_o = (count_q >= umbral_i);
    assign count_o       = count_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

endmodule

// File: rtl/fifo_banco_dispositivos.sv
// Bank of independent per-device FIFO channels.
// Each channel owns its own slice of every packed bus.
module fifo_banco_dispositivos
    import fifo_pkg::*;
#(
    parameter int width   = 16,
    parameter int depth   = 8,
    parameter int devices = 4,
    parameter int fwft    = MODO_REG,
    localparam int cnt_w  = calc_cnt_w(depth)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [devices*width-1:0]   dato_i,
    input  logic [devices-1:0]         push_i,
    input  logic [devices-1:0]         pop_i,
    input  logic [devices*cnt_w-1:0]   umbral_i,
    input  logic [devices-1:0]         clr_flags_i,
    output logic [devices*width-1:0]   dato_o,
    output logic [devices-1:0]         pndng_o,
    output logic [devices-1:0]         full_o,
    output logic [devices-1:0]         almost_full_o,
    output logic [devices*cnt_w-1:0]   count_o,
    output logic [devices-1:0]         overflow_o,
    output logic [devices-1:0]         underflow_o
);

    for (genvar k = 0; k < devices; k++) begin : g_canal
        fifo_canal #(
            .width (width),
            .depth (depth),
            .fwft  (fwft)
        ) u_canal (
            .clk           (clk),
            .rst_n         (rst_n),
            .dato_i        (dato_i[k*width +: width]),
            .push_i        (push_i[k]),
            .pop_i         (pop_i[k]),
            .umbral_i      (umbral_i[k*cnt_w +: cnt_w]),
            .clr_flags_i   (clr_flags_i[k]),
            .dato_o        (dato_o[k*width +: width]),
            .pndng_o       (pndng_o[k]),
            .full_o        (full_o[k]),
            .almost_full_o (almost_full_o[k]),
            .count_o       (count_o[k*cnt_w +: cnt_w]),
            .overflow_o    (overflow_o[k]),
            .underflow_o   (underflow_o[k])
        );
    end

endmodule

// File: tb/tb_fifo_banco_dispositivos.sv
// Bench for the FIFO bank: registered-read bank of 4 x depth 8
// plus a single fall-through channel of depth 5 as channel 4.
module tb_fifo_banco_dispositivos;

    localparam int NCH = 5;

    typedef struct packed {
        logic [NCH-1:0][3:0]  cnt;
        logic [NCH-1:0]       pnd;
        logic [NCH-1:0]       ful;
        logic [NCH-1:0]       af;
        logic [NCH-1:0]       ov;
        logic [NCH-1:0]       un;
        logic [NCH-1:0][15:0] dat;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] dato_i, dato_o;
    logic [3:0]  push_i, pop_i, clr_i;
    logic [3:0]  pndng_o, full_o, af_o, ovf_o, unf_o;
    logic [15:0] umbral_i, count_o;

    logic [15:0] f_dato_i, f_dato_o;
    logic        f_push, f_pop, f_clr;
    logic        f_pnd, f_full, f_af, f_ovf, f_unf;
    logic [2:0]  f_umb, f_cnt;

    fifo_banco_dispositivos #(
        .width(16), .depth(8), .devices(4), .fwft(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dato_i(dato_i), .push_i(push_i), .pop_i(pop_i),
        .umbral_i(umbral_i), .clr_flags_i(clr_i),
        .dato_o(dato_o), .pndng_o(pndng_o), .full_o(full_o),
        .almost_full_o(af_o), .count_o(count_o),
        .overflow_o(ovf_o), .underflow_o(unf_o)
    );

    fifo_banco_dispositivos #(
        .width(16), .depth(5), .devices(1), .fwft(1)
    ) dut_f (
        .clk(clk), .rst_n(rst_n),
        .dato_i(f_dato_i), .push_i(f_push), .pop_i(f_pop),
        .umbral_i(f_umb), .clr_flags_i(f_clr),
        .dato_o(f_dato_o), .pndng_o(f_pnd), .full_o(f_full),
        .almost_full_o(f_af), .count_o(f_cnt),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    // Actual outputs gathered into per-channel form.
    logic [NCH-1:0][3:0]  a_cnt;
    logic [NCH-1:0][15:0] a_dat;
    logic [NCH-1:0]       a_pnd, a_ful, a_af, a_ov, a_un;

    always_comb begin
        a_cnt = '0;
        a_dat = '0;
        for (int c = 0; c < 4; c++) begin
            a_cnt[c] = count_o[c*4 +: 4];
            a_dat[c] = dato_o[c*16 +: 16];
        end
        a_cnt[4] = {1'b0, f_cnt};
        a_dat[4] = f_dato_o;
    end
    assign a_pnd = {f_pnd, pndng_o};
    assign a_ful = {f_full, full_o};
    assign a_af  = {f_af, af_o};
    assign a_ov  = {f_ovf, ovf_o};
    assign a_un  = {f_unf, unf_o};

    // Stimulus for the next cycle.
    logic [NCH-1:0] s_push, s_pop, s_clr;
    logic [15:0]    s_dat [NCH];
    int             s_umb [NCH];

    // Reference model: plain queues and flags.
    logic [15:0]    mq   [NCH][$];
    logic [15:0]    rd_q [NCH][$];
    logic [NCH-1:0] m_ov, m_un;
    logic [15:0]    m_last [NCH];
    snap_t          st_q [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int ch,
                       input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s ch%0d act=%0h exp=%0h t=%0t",
                     nm, ch, a, e, $time);
        end
    endtask

    function automatic int dep(input int ch);
        return (ch == 4) ? 5 : 8;
    endfunction

    task automatic aplicar();
        for (int c = 0; c < 4; c++) begin
            dato_i[c*16 +: 16] = s_dat[c];
            umbral_i[c*4 +: 4] = 4'(s_umb[c]);
        end
        push_i   = s_push[3:0];
        pop_i    = s_pop[3:0];
        clr_i    = s_clr[3:0];
        f_dato_i = s_dat[4];
        f_umb    = 3'(s_umb[4]);
        f_push   = s_push[4];
        f_pop    = s_pop[4];
        f_clr    = s_clr[4];
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            rd_q[c].delete();
            m_last[c] = '0;
        end
        m_ov = '0;
        m_un = '0;
        st_q.delete();
    endtask

    // One clock of stimulus; model predicts the post-edge state.
    task automatic step();
        snap_t sn;
        int n, dp, sz;
        bit pok, wok;
        @(negedge clk);
        aplicar();
        sn = '0;
        for (int c = 0; c < NCH; c++) begin
            n   = mq[c].size();
            dp  = dep(c);
            pok = s_pop[c] && (n > 0);
            wok = s_push[c] && ((n < dp) || s_pop[c]);
            if (pok) begin
                m_last[c] = mq[c].pop_front();
                if (c < 4) rd_q[c].push_back(m_last[c]);
            end
            if (wok) mq[c].push_back(s_dat[c]);
            if (s_clr[c]) begin
                m_ov[c] = 1'b0;
                m_un[c] = 1'b0;
            end else begin
                if (s_push[c] && n == dp && !s_pop[c]) m_ov[c] = 1'b1;
                if (s_pop[c] && n == 0) m_un[c] = 1'b1;
            end
            sz = mq[c].size();
            sn.cnt[c] = 4'(sz);
            sn.pnd[c] = (sz != 0);
            sn.ful[c] = (sz == dp);
            sn.af[c]  = (sz >= s_umb[c]);
            sn.ov[c]  = m_ov[c];
            sn.un[c]  = m_un[c];
            sn.dat[c] = (c == 4 && sz > 0) ? mq[c][0] : m_last[c];
        end
        st_q.push_back(sn);
        s_push = '0;
        s_pop  = '0;
        s_clr  = '0;
    endtask

    // Asserts reset, checks the cleared state at once, then releases.
    task automatic reset_chk();
        rst_n  = 1'b0;
        s_push = '0;
        s_pop  = '0;
        s_clr  = '0;
        aplicar();
        #1;
        for (int c = 0; c < NCH; c++) begin
            chk("rst_cnt", c, 32'(a_cnt[c]), 32'd0);
            chk("rst_pnd", c, 32'(a_pnd[c]), 32'd0);
            chk("rst_full", c, 32'(a_ful[c]), 32'd0);
            chk("rst_ovf", c, 32'(a_ov[c]), 32'd0);
            chk("rst_unf", c, 32'(a_un[c]), 32'd0);
            chk("rst_dato", c, 32'(a_dat[c]), 32'd0);
            chk("rst_af", c, 32'(a_af[c]), 32'(s_umb[c] == 0));
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rnd_steps(input int n, input int pp, input int pq);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < NCH; c++) begin
                s_push[c] = ($urandom_range(99) < pp);
                s_pop[c]  = ($urandom_range(99) < pq);
                s_clr[c]  = ($urandom_range(49) == 0);
                s_dat[c]  = 16'($urandom);
                if ($urandom_range(39) == 0)
                    s_umb[c] = (c == 4) ? $urandom_range(7)
                                        : $urandom_range(10);
            end
            step();
        end
    endtask

    // Monitor: compares every cycle and pops read data on accepted pops.
    initial begin
        logic [NCH-1:0] prev_pnd;
        logic [NCH-1:0] acc;
        snap_t s;
        logic [15:0] e;
        prev_pnd = '0;
        forever begin
            @(posedge clk);
            acc = {f_pop, pop_i} & prev_pnd;
            #1;
            if (rst_n && st_q.size() > 0) begin
                s = st_q.pop_front();
                for (int c = 0; c < NCH; c++) begin
                    chk("cnt", c, 32'(a_cnt[c]), 32'(s.cnt[c]));
                    chk("pnd", c, 32'(a_pnd[c]), 32'(s.pnd[c]));
                    chk("full", c, 32'(a_ful[c]), 32'(s.ful[c]));
                    chk("af", c, 32'(a_af[c]), 32'(s.af[c]));
                    chk("ovf", c, 32'(a_ov[c]), 32'(s.ov[c]));
                    chk("unf", c, 32'(a_un[c]), 32'(s.un[c]));
                    chk("dato", c, 32'(a_dat[c]), 32'(s.dat[c]));
                end
                for (int c = 0; c < 4; c++) begin
                    if (acc[c]) begin
                        if (rd_q[c].size() == 0) begin
                            chk("rd_extra", c, 32'd1, 32'd0);
                        end else begin
                            e = rd_q[c].pop_front();
                            chk("rd", c, 32'(a_dat[c]), 32'(e));
                        end
                    end
                end
            end
            prev_pnd = a_pnd;
        end
    end

    initial begin
        rst_n  = 1'b0;
        s_push = '0;
        s_pop  = '0;
        s_clr  = '0;
        dato_i = '0;
        umbral_i = '0;
        for (int c = 0; c < NCH; c++) begin
            s_dat[c] = '0;
            s_umb[c] = (c == 0) ? 0 : 3;
        end
        model_clear();
        reset_chk();

        // Two words through channel 0.
        s_umb[0] = 9;
        s_push[0] = 1'b1; s_dat[0] = 16'h0006; step();
        s_push[0] = 1'b1; s_dat[0] = 16'h000A; step();
        s_pop[0] = 1'b1; step();
        s_pop[0] = 1'b1; step();
        step();

        // Overflow on channel 2, drain, then clear.
        for (int i = 0; i < 8; i++) begin
            s_push[2] = 1'b1; s_dat[2] = 16'h0100 + 16'(i); step();
        end
        s_push[2] = 1'b1; s_dat[2] = 16'hDEAD; step();
        for (int i = 0; i < 8; i++) begin
            s_pop[2] = 1'b1; step();
        end
        s_clr[2] = 1'b1; step();

        // Push and pop together on a full channel 1.
        for (int i = 0; i < 8; i++) begin
            s_push[1] = 1'b1; s_dat[1] = 16'h0200 + 16'(i); step();
        end
        s_push[1] = 1'b1; s_pop[1] = 1'b1; s_dat[1] = 16'hBEEF; step();
        for (int i = 0; i < 8; i++) begin
            s_pop[1] = 1'b1; step();
        end

        // Pop on empty channel 3 with a simultaneous push.
        s_pop[3] = 1'b1; s_push[3] = 1'b1; s_dat[3] = 16'h0033; step();
        s_pop[3] = 1'b1; step();
        s_clr[3] = 1'b1; step();

        // Almost-full threshold on channel 0.
        s_umb[0] = 6;
        for (int i = 0; i < 6; i++) begin
            s_push[0] = 1'b1; s_dat[0] = 16'h0A00 + 16'(i); step();
        end
        s_pop[0] = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            s_pop[0] = 1'b1; step();
        end

        // Fall-through channel: visibility, then three fill/drain rounds.
        s_push[4] = 1'b1; s_dat[4] = 16'h0011; step();
        step();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) begin
                s_push[4] = 1'b1;
                s_dat[4] = 16'h0400 + 16'(r * 8 + i);
                step();
            end
            for (int i = 0; i < 5; i++) begin
                s_pop[4] = 1'b1; step();
            end
        end

        // Random traffic with varying fill pressure.
        rnd_steps(150, 80, 30);
        rnd_steps(150, 30, 80);
        rnd_steps(150, 55, 50);
        @(posedge clk);
        #2;
        reset_chk();
        rnd_steps(200, 85, 25);
        rnd_steps(200, 50, 50);
        @(posedge clk);
        #2;
        reset_chk();
        rnd_steps(100, 60, 60);

        repeat (3) @(negedge clk);
        chk("snap_left", 0, 32'(st_q.size()), 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("rd_left", c, 32'(rd_q[c].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
